shift_issue: RTL

- Execute-stage wrapper feeding the core's combinational bidirectional arithmetic shifter. Ports: `distance`, `data`, `direction` (1 = arithmetic right), `result`.
- Decodes SLL/SRL/SRA and their variable forms, and registers operands into the shifter.
- Post-masks the shifter output to produce logical right shifts.
- Registers the result with tag for writeback, using a valid/ready handshake on both sides.

---
 rtl/shift_issue.sv | 133 +++++++++++++
 1 files changed

// File: rtl/shift_issue.sv
// Execute-stage wrapper around the core's combinational bidirectional shifter.
//
// Purpose:
//   S1 decodes SLL/SRL/SRA (immediate or variable distance) and registers the operands
//   that feed the external shifter. S2 captures the shifter result and post-masks it so
//   an arithmetic right shift becomes a logical one for SRL. Both sides use valid/ready.
//
// Ports:
//   clock, rst_n     clock and asynchronous active-low reset
//   flush            synchronous pipeline kill (drops S1 and S2, blocks accept)
//   in_*             request: op, var select, shamt, rs (distance source), rt (data), tag
//   sh_*             to/from the combinational shifter (distance, data, direction, result)
//   out_*            result with destination tag, valid/ready handshake
//   busy             any stage holds an op
module shift_issue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DISTW = 5,
    parameter int unsigned TAGW  = 5
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_var,
    input  logic [DISTW-1:0] in_shamt,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic [TAGW-1:0]  in_tag,
    output logic [DISTW-1:0] sh_distance,
    output logic [WIDTH-1:0] sh_data,
    output logic             sh_direction,
    input  logic [WIDTH-1:0] sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic             busy
);

    // S1 state
    logic             s1_valid_q;
    logic             s1_logical_q;
    logic [TAGW-1:0]  s1_tag_q;
    logic [DISTW-1:0] sh_distance_q;
    logic [WIDTH-1:0] sh_data_q;
    logic             sh_direction_q;

    // S2 state
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic [TAGW-1:0]  out_tag_q;

    logic             s2_free;
    logic             accept;
    logic             move;
    logic [DISTW-1:0] dist_d;
    logic [WIDTH-1:0] result_d;

    // Only the low DISTW bits of rs select the distance; the rest wrap away.
    logic unused_rs;
    assign unused_rs = ^in_rs[WIDTH-1:DISTW];

    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !flush && (!s1_valid_q || s2_free);
    assign accept   = in_valid && in_ready;
    assign move     = s1_valid_q && s2_free && !flush;

    assign dist_d = in_var ? in_rs[DISTW-1:0] : in_shamt;

    // The shifter only does arithmetic right; clearing the top `distance` bits turns it
    // into a logical right shift. Distance 0 gives an all-ones mask.
    always_comb begin
        result_d = sh_result;
        if (s1_logical_q) begin
            result_d = sh_result & ({WIDTH{1'b1}} >> sh_distance_q);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q     <= 1'b0;
            s1_logical_q   <= 1'b0;
            s1_tag_q       <= '0;
            sh_distance_q  <= '0;
            sh_data_q      <= '0;
            sh_direction_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_tag_q      <= '0;
        end else begin
            // S1 valid: new accept wins over drain so a simultaneous move+accept stays full.
            if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (accept) begin
                s1_valid_q <= 1'b1;
            end else if (move) begin
                s1_valid_q <= 1'b0;
            end

            if (accept) begin
                sh_distance_q  <= dist_d;
                sh_data_q      <= in_rt;
                sh_direction_q <= in_op[1];
                s1_logical_q   <= (in_op == 2'b10);
                s1_tag_q       <= in_tag;
            end

            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (move) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (move) begin
                out_result_q <= result_d;
                out_tag_q    <= s1_tag_q;
            end
        end
    end

    assign sh_distance  = sh_distance_q;
    assign sh_data      = sh_data_q;
    assign sh_direction = sh_direction_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_tag      = out_tag_q;
    assign busy         = s1_valid_q || out_valid_q;

endmodule
